// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
// The optional parity bit is enabled by defining SER_PARITY_EN at build time.
package ser_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    localparam logic SER_IDLE_LVL = 1'b0;

    // The counter must hold FRAME-1, which can be as large as WIDTH when parity is on.
    function automatic int ser_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// Loadable down-counter that tracks the remaining bits of a frame.
// It saturates at zero, so the 'last' flag holds until the next load.
module ser_bit_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          r,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          last
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign last = (r_cnt == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts a word on load/ready and shifts it out MSB-first.
// Define SER_PARITY_EN to append an even-parity bit after the LSB of every frame.
//
// Handshake: a word is taken on a rising edge where load & ready is high. ready depends
// only on state and bit counter (never on load); upstream holds din/load until accepted.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sdo,
    output logic             bit_valid,
    output logic             done,
    output ser_state_t       state_dbg
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW       = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(FRAME - 1);

    ser_state_t       r_state;
    ser_state_t       w_next_state;
    logic [FRAME-1:0] r_shreg;
    logic [FRAME-1:0] w_frame;
    logic             r_sdo;
    logic             w_last;
    logic             w_accept;
    logic             w_shift;

`ifdef SER_PARITY_EN
    assign w_frame = {din, ^din};
`else
    assign w_frame = din;
`endif

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    ready = 1'b1;
                    done  = 1'b1;
                    if (load) begin
                        w_accept = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // The first frame bit is registered straight onto the line at accept time.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_shreg <= '0;
            r_sdo   <= SER_IDLE_LVL;
        end else if (w_accept) begin
            r_sdo   <= w_frame[FRAME-1];
            r_shreg <= {w_frame[FRAME-2:0], 1'b0};
        end else if (w_shift && !w_last) begin
            r_sdo   <= r_shreg[FRAME-1];
            r_shreg <= {r_shreg[FRAME-2:0], 1'b0};
        end else if (w_next_state == S_IDLE) begin
            r_sdo   <= SER_IDLE_LVL;
        end
    end

    ser_bit_cnt #(
        .CW (CW)
    ) u_bit_cnt (
        .clk      (clk),
        .r        (r),
        .load     (w_accept),
        .load_val (CNT_INIT),
        .dec      (w_shift),
        .last     (w_last)
    );

    assign sdo       = r_sdo;
    assign bit_valid = (r_state == S_SHIFT);
    assign state_dbg = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer; frame length follows SER_PARITY_EN.
module tb_bit_serializer;
    import ser_pkg::*;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk;
    logic         r;
    logic [W-1:0] din;
    logic         load;
    logic         ready;
    logic         sdo;
    logic         bit_valid;
    logic         done;
    ser_state_t   state_dbg;

    int n_chk  = 0;
    int n_pass = 0;
    logic mon_en = 1'b0;

    // Each entry: [1] expected sdo bit, [0] expected done for that bit.
    logic [1:0] exp_q[$];

    bit_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .r         (r),
        .din       (din),
        .load      (load),
        .ready     (ready),
        .sdo       (sdo),
        .bit_valid (bit_valid),
        .done      (done),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_frame(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back({d[i], logic'(i == 0 && FRAME == W)});
        end
        if (FRAME != W) begin
            exp_q.push_back({^d, 1'b1});
        end
    endtask

    // Scoreboard: pop one expected bit per valid cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bit_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected_bit: got sdo=%b with no bit expected at %0t", sdo, $time);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    n_chk++;
                    if (sdo !== e[1]) $display("FAIL sb_sdo: got %b expected %b at %0t", sdo, e[1], $time);
                    else n_pass++;
                    n_chk++;
                    if (done !== e[0]) $display("FAIL sb_done: got %b expected %b at %0t", done, e[0], $time);
                    else n_pass++;
                end
            end else begin
                n_chk++;
                if (sdo !== 1'b0 || done !== 1'b0 || bit_valid !== 1'b0)
                    $display("FAIL sb_idle_line: got sdo=%b done=%b bv=%b expected 0/0/0 at %0t",
                             sdo, done, bit_valid, $time);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        r = 1'b0; load = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (ready !== 1'b1 || sdo !== 1'b0 || bit_valid !== 1'b0)
            $display("FAIL reset_hold: got rdy=%b sdo=%b bv=%b expected 1/0/0", ready, sdo, bit_valid);
        else n_pass++;
        // load during reset must not start a frame
        load = 1'b1; din = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        r = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_chk++;
            if (ready !== 1'b1 || bit_valid !== 1'b0 || sdo !== 1'b0 || state_dbg !== S_IDLE)
                $display("FAIL reset_idle: cycle %0d got rdy=%b bv=%b sdo=%b expected 1/0/0", k, ready, bit_valid, sdo);
            else n_pass++;
        end
    endtask

    task automatic test_single(input logic [W-1:0] d);
        @(negedge clk);
        din = d; load = 1'b1;
        n_chk++;
        if (ready !== 1'b1) $display("FAIL single_ready_idle: got %b expected 1", ready);
        else n_pass++;
        push_frame(d);
        @(negedge clk);
        load = 1'b0; din = W'($urandom_range(0, 255));
        for (int k = 1; k <= FRAME; k++) begin
            n_chk++;
            if (ready !== logic'(k == FRAME) || bit_valid !== 1'b1)
                $display("FAIL single_ready: cycle t+%0d got rdy=%b bv=%b expected %b/1", k, ready, bit_valid, k == FRAME);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++;
        if (bit_valid !== 1'b0 || ready !== 1'b1)
            $display("FAIL single_end: got bv=%b rdy=%b expected 0/1", bit_valid, ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        din = 8'hB0; load = 1'b1;
        push_frame(8'hB0);
        @(negedge clk);
        din = 8'h0F;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            n_chk++;
            if (bit_valid !== 1'b1 || ready !== logic'(k == FRAME || k == 2 * FRAME))
                $display("FAIL b2b_stream: cycle t+%0d got bv=%b rdy=%b expected 1/%b",
                         k, bit_valid, ready, (k == FRAME || k == 2 * FRAME));
            else n_pass++;
            if (k == FRAME) push_frame(8'h0F);
            @(negedge clk);
            if (k == FRAME) load = 1'b0;
        end
        n_chk++;
        if (bit_valid !== 1'b0) $display("FAIL b2b_end: got bv=%b expected 0", bit_valid);
        else n_pass++;
    endtask

    task automatic test_load_mid_frame();
        @(negedge clk);
        din = 8'hB0; load = 1'b1;
        push_frame(8'hB0);
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        din = 8'hFF; load = 1'b1;
        n_chk++;
        if (ready !== 1'b0) $display("FAIL midload_ready: got %b expected 0", ready);
        else n_pass++;
        @(negedge clk);
        load = 1'b0; din = '0;
        repeat (FRAME - 2) @(negedge clk);
        n_chk++;
        if (bit_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL midload_end: got bv=%b pending=%0d expected 0/0", bit_valid, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        din = 8'hB0; load = 1'b1;
        push_frame(8'hB0);
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #2 r = 1'b0;
        #1;
        n_chk++;
        if (sdo !== 1'b0 || bit_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1)
            $display("FAIL async_abort: got sdo=%b bv=%b done=%b rdy=%b expected 0/0/0/1", sdo, bit_valid, done, ready);
        else n_pass++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        r = 1'b1;
        repeat (2) @(negedge clk);
        test_single(8'h81);
    endtask

    task automatic test_stream(input int n_words);
        logic [W-1:0] w;
        w = 8'h33;
        @(negedge clk);
        din = w; load = 1'b1;
        push_frame(w);
        for (int i = 1; i < n_words; i++) begin
            w = W'($urandom_range(0, 255));
            for (int k = 1; k <= FRAME; k++) begin
                @(negedge clk);
                if (k == 1) din = w;
            end
            n_chk++;
            if (ready !== 1'b1) $display("FAIL stream_ready: word %0d got %b expected 1", i, ready);
            else n_pass++;
            push_frame(w);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (FRAME) @(negedge clk);
        n_chk++;
        if (bit_valid !== 1'b0) $display("FAIL stream_end: got bv=%b expected 0", bit_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single(8'hB0);
        test_single(8'h33);
        test_back_to_back();
        test_load_mid_frame();
        test_reset_mid_frame();
        test_stream(6);
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL drain: got %0d pending bits expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
